bus_mem_responder: RTL
======================

# bus_mem_responder

Word-wide bus responder: the memory-side end of the 32-bit single-beat bus that line buffers use to move 128-bit cache lines as four word transfers. It accepts one read or write per handshake, waits a configurable number of cycles, pulses `bus_ready`, and serves from an internal synchronous word RAM. It is the main-memory model and target behind the cache/line-buffer path.

## Interface
Parameters:
- `ADDR_W`, 10: word-address bits; RAM depth is 2^ADDR_W words.
- `LATENCY`, 2: wait cycles inserted between request acceptance and `bus_ready`; legal range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `bus_r`  in  1  read request, held by the initiator until it samples `bus_ready`.
- `bus_w`  in  1  write request, held the same way.
- `bus_addr`  in  32  byte address; bits [1:0] ignored.
- `bus_wdata`  in  32  write data; valid whenever `bus_w` is high.
- `bus_rdata`  out  32  read data; valid in the cycle `bus_ready` is high, then held until the next read completes.
- `bus_ready`  out  1  one-cycle completion pulse, registered.
- `bus_err`  out  1  present only with `BUS_MEM_RANGE_CHECK_EN`.

## Operation
- FSM states:
  - IDLE: if `bus_r | bus_w`, latch op, word index `bus_addr[ADDR_W+1:2]`, full address, and `bus_wdata`. Go to WAIT when `LATENCY > 0`, otherwise to ACK.
  - WAIT: 4-bit counter loaded with `LATENCY-1` on entry and decremented each cycle. At 0, go to ACK.
  - ACK: `bus_ready = 1` for exactly this cycle, then go to IDLE unconditionally.
- Op priority: `bus_r` and `bus_w` both high is treated as a write, matching the initiator's write-first decode.
- Write commit: RAM is written at the clock edge entering ACK, using the latched index and data.
- Read: `bus_rdata` is loaded at the edge entering ACK from RAM at the latched index. It keeps its value on writes and in idle cycles.
- Request capture: the request is captured only in IDLE. Changes to `bus_addr`/`bus_wdata` after capture are ignored until the next IDLE.
- Request withdrawn mid-WAIT (protocol violation): the responder still completes. The write is still committed and `bus_ready` still pulses.
- Address aliasing: upper address bits [31:ADDR_W+2] are ignored, so addresses alias modulo the RAM size.
- RAM contents are not affected by `rst`.

## Timing
- Reset values: state IDLE, `bus_ready` 0, `bus_rdata` 32'h0, `bus_err` 0, counter 0.
- Latency: request first high in cycle t (responder in IDLE) gives `bus_ready` high in cycle t+1+LATENCY.
  - One beat occupies LATENCY+2 cycles.
  - Four-beat line transfer takes 4·(LATENCY+2) cycles.
- Back-to-back beats: the initiator presents the next address in the cycle after `bus_ready`. The responder is back in IDLE in that cycle and accepts it with no bubble.
- `rst` asserted in any state: returns to IDLE immediately. An in-flight write not yet committed is dropped; `bus_ready` is forced to 0.

## Configuration
- `BUS_MEM_RANGE_CHECK_EN` defined:
  - Adds the `bus_err` output, registered alongside `bus_ready` and high only in the ACK cycle.
  - `bus_err` is set when latched address bits [31:ADDR_W+2] are nonzero.
  - An erroring write is suppressed; an erroring read returns 32'h0.
- Undefined: no `bus_err` port; aliasing as described under Operation.

## Structure
- Shared header `bus_defs.vh`:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - op constants (OP_RD, OP_WR);
  - the 32-bit bus data/address width constant, also used by the line buffer.
- Sub-module `bus_word_ram`: single-port RAM, parameterised on ADDR_W, with synchronous write, synchronous read, and no reset.
- FSM, counter and latch registers live in the top module.

## Test plan
- Reset then idle: `rst` pulse with no requests -> `bus_ready`=0 and `bus_rdata`=0 for 20 cycles.
- Single write then read, LATENCY=2: write 0xDEADBEEF to 0x40, then read 0x40 -> each `bus_ready` pulse lands 3 cycles after request; read returns 0xDEADBEEF.
- Four-beat line write then line read at 0x100..0x10C, data 0x11111111..0x44444444, driven by the line buffer -> its `ready` asserts and the 128-bit read equals 0x44444444_33333333_22222222_11111111; each transfer takes 16 bus cycles.
- LATENCY=0: back-to-back reads of 0x0 and 0x4 -> `bus_ready` high in cycles t+1 and t+3 with correct data.
- Reset mid-WAIT during a write of 0xCAFEF00D to 0x80 -> no `bus_ready`; a later read of 0x80 returns the prior contents.
- With `BUS_MEM_RANGE_CHECK_EN`: write 0x12345678 to 0x0001_0000 (ADDR_W=10) -> `bus_err`=1 together with `bus_ready`; word 0 is unchanged; a read of the same address returns 0 with `bus_err`=1.

Source files
------------

// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the word-wide memory responder: bus width,
// FSM state encodings, operation codes and small decode helpers.
package bus_mem_responder_pkg;

  // Bus data/address width, shared with the line buffer side of the bus.
  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // A request with both read and write raised is a write (write-first decode).
  function automatic op_e decode_op(input logic wr);
    op_e op;
    if (wr) begin
      op = OP_WR;
    end else begin
      op = OP_RD;
    end
    return op;
  endfunction

  // True when any address bit above the RAM's word index range is set.
  function automatic logic addr_out_of_range(input logic [BUS_W-1:0] addr,
                                             input int unsigned addr_w);
    logic [BUS_W-1:0] upper;
    upper = addr >> (addr_w + 32'd2);
    return (upper != {BUS_W{1'b0}});
  endfunction

endpackage

// File: rtl/bus_word_ram.sv
// Single-port word RAM: synchronous write, synchronous read with read
// enable, no reset on the array or the read register.
module bus_word_ram
  import bus_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BUS_W-1:0]  wdata_i,
  output logic [BUS_W-1:0]  rdata_o
);

  logic [BUS_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [BUS_W-1:0] rdata_q;

  // Commit a write into the array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only updates on an enabled read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the 32-bit single-beat bus. Accepts one read or
// write per handshake, waits LATENCY cycles, then pulses bus_ready for one
// cycle. Optional feature macro: BUS_MEM_RANGE_CHECK_EN adds bus_err and
// rejects addresses outside the RAM instead of aliasing them.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_r,
  input  logic             bus_w,
  input  logic [BUS_W-1:0] bus_addr,
  input  logic [BUS_W-1:0] bus_wdata,
  output logic [BUS_W-1:0] bus_rdata,
  output logic             bus_ready
`ifdef BUS_MEM_RANGE_CHECK_EN
  ,
  output logic             bus_err
`endif
);

  // Wait counter starts one below LATENCY so that WAIT lasts LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic              err_pend_q, err_pend_d;
  logic              ready_q;
  logic              err_q;
  logic              rdata_zero_q;

  logic              req_err_s;
  op_e               eff_op_s;
  logic [ADDR_W-1:0] eff_idx_s;
  logic [BUS_W-1:0]  eff_wdata_s;
  logic              eff_err_s;
  logic              enter_ack_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [BUS_W-1:0]  ram_rdata_s;

`ifdef BUS_MEM_RANGE_CHECK_EN
  assign req_err_s = addr_out_of_range(bus_addr, ADDR_W);
  assign bus_err   = err_q;
`else
  // Upper address bits alias and byte-offset bits are don't-care here.
  logic unused_s;
  assign req_err_s = 1'b0;
  assign unused_s  = ^{bus_addr[1:0], bus_addr[BUS_W-1:ADDR_W+2], err_q};
`endif

  // Effective request: live bus inputs while idle (needed for LATENCY=0),
  // latched copy once the request has been captured.
  always_comb begin
    eff_op_s    = op_q;
    eff_idx_s   = idx_q;
    eff_wdata_s = wdata_q;
    eff_err_s   = err_pend_q;
    if (state_q == ST_IDLE) begin
      eff_op_s    = decode_op(bus_w);
      eff_idx_s   = bus_addr[ADDR_W+1:2];
      eff_wdata_s = bus_wdata;
      eff_err_s   = req_err_s;
    end else begin
      eff_op_s    = op_q;
      eff_idx_s   = idx_q;
      eff_wdata_s = wdata_q;
      eff_err_s   = err_pend_q;
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, single ACK cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_pend_d = err_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_r || bus_w) begin
          op_d       = eff_op_s;
          idx_d      = eff_idx_s;
          wdata_d    = eff_wdata_s;
          err_pend_d = eff_err_s;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_ACK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM access happens on the edge that enters ACK; erroring accesses are blocked.
  assign enter_ack_s = (state_d == ST_ACK);
  assign ram_we_s    = enter_ack_s && (eff_op_s == OP_WR) && !eff_err_s;
  assign ram_re_s    = enter_ack_s && (eff_op_s == OP_RD) && !eff_err_s;

  // FSM, counter and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= OP_RD;
      idx_q      <= {ADDR_W{1'b0}};
      wdata_q    <= {BUS_W{1'b0}};
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Completion pulse and error flag, registered together for the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= enter_ack_s;
      err_q   <= enter_ack_s && eff_err_s;
    end
  end

  // Read data is forced to zero after reset and after an erroring read, until
  // the next good read refreshes the RAM read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_zero_q <= 1'b1;
    end else if (enter_ack_s && (eff_op_s == OP_RD)) begin
      rdata_zero_q <= eff_err_s;
    end else begin
      rdata_zero_q <= rdata_zero_q;
    end
  end

  bus_word_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .addr_i  (eff_idx_s),
    .wdata_i (eff_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign bus_rdata = rdata_zero_q ? {BUS_W{1'b0}} : ram_rdata_s;
  assign bus_ready = ready_q;

endmodule
